jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
- Shares a bank of NFF JK flip-flops between NREQ requesters.
- Each requester asks for one operation (hold, clear, set or toggle) on one flop of the bank.
- The block arbitrates round-robin, drives the selected flop's J/K inputs for exactly one clock, reads back the flop's new Q, and acknowledges the requester.
- It sits between the requesting logic and the instantiated JK flip-flop bank, and is the only driver of the bank's J/K lines.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFF, 8, number of JK flip-flops in the bank.
- IDXW, 3, width of the flop index field; must satisfy 2**IDXW >= NFF.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; held high until that requester's ack.
- op  input  2*NREQ  per-requester opcode, requester r at bits [2r+1:2r]; 00 hold, 01 clear, 10 set, 11 toggle (bit1 = J, bit0 = K).
- idx  input  IDXW*NREQ  per-requester target flop index, requester r at bits [IDXW*r+IDXW-1:IDXW*r].
- q_in  input  NFF  Q outputs fed back from the flop bank.
- j_out  output  NFF  J inputs to the flop bank.
- k_out  output  NFF  K inputs to the flop bank.
- ack  output  NREQ  one-cycle completion pulse, one-hot.
- rdata  output  1  Q of the target flop after the operation; valid while ack is high.
- err  output  1  index was out of range (idx >= NFF); valid while ack is high.
- busy  output  1  high whenever the FSM is not in IDLE.
- gnt_id  output  clog2(NREQ)  index of the current or last granted requester.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, ptr=0, j_out=0, k_out=0, ack=0, rdata=0, err=0, busy=0, gnt_id=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states are IDLE, DRIVE, CHECK and DONE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise choose winner g as the first set bit searching from ptr upward, wrapping modulo NREQ.
  - Latch op[g] and idx[g], set gnt_id=g, busy=1, and go to DRIVE.
  - If the latched idx < NFF, set j_out[idx]=op[1] and k_out[idx]=op[0]; all other J/K bits stay 0.
  - If the latched idx >= NFF, drive no J/K bits and set an internal error flag.
- DRIVE (exactly one cycle, J/K pattern is stable): the flop updates at the closing edge. Next state is CHECK, with j_out=0 and k_out=0.
- CHECK (one cycle, q_in now reflects the new value): next state is DONE. At this edge:
  - ack[g]=1.
  - rdata=q_in[idx], or 0 on error.
  - err = error flag.
- DONE (one cycle): next state is IDLE. At this edge:
  - ack=0, busy=0.
  - ptr=(g+1) mod NREQ.
  - rdata and err hold their values until the next grant.
- Timing: a request sampled at edge E0 produces j/k high during [E0,E1), and ack high during [E2,E3). One operation completes every 4 cycles when requests are back-to-back.
- Opcode 00 still runs the full sequence with J/K all 0, and returns the current Q. This is the read path.
- Requesters must hold req, op and idx until ack. Only the values latched in IDLE are used. If req drops mid-operation, the operation still completes and ack still pulses.
- A requester that keeps req high after its ack is a new request. Round-robin rotation prevents it from starving the others.
- At most one j_out/k_out bit pair is ever nonzero, and only in DRIVE.
- Reset mid-operation aborts immediately: J/K drop to 0, no ack is issued, and ptr returns to 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> j_out=k_out=0, ack=0, busy=0 held for 10 cycles.
- Single set then toggle (flop 5 starts at 0):
  - Req0 op=10 idx=5 -> j_out=0x20 for exactly one cycle; ack=0001 two cycles later with rdata=1.
  - Then op=11 idx=5 -> rdata=0.
- Round-robin fairness: req=1111 held continuously, every requester targeting a distinct flop with op=10 -> ack order 0,1,2,3,0; each ack 4 cycles apart; gnt_id follows.
- Hold/read: req2 op=00 idx=3 with q_in[3]=1 -> j_out and k_out stay 0 throughout; ack=0100, rdata=1, err=0.
- Out of range (NFF=6): req1 idx=7 op=10 -> no J/K activity; ack=0010 with err=1, rdata=0.
- Reset mid-operation: assert rst during DRIVE -> j_out and k_out go to 0 immediately, no ack, ptr=0; the next request from req3 is served normally.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : jk_bank_arbiter
//  Purpose  : Round-robin arbiter sharing a bank of JK flip-flops between
//             several requesters. Each granted operation pulses the target
//             flop's J/K for one clock, reads the new Q back and acks.
//  Revision : 1.0  initial release
// ============================================================================
module jk_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  parameter int IDXW = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        op,
  input  logic [IDXW*NREQ-1:0]     idx,
  input  logic [NFF-1:0]           q_in,
  output logic [NFF-1:0]           j_out,
  output logic [NFF-1:0]           k_out,
  output logic [NREQ-1:0]          ack,
  output logic                     rdata,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  gnt_id
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              oor_q, oor_d;
  logic [NFF-1:0]    j_q, j_d;
  logic [NFF-1:0]    k_q, k_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              win_found;
  logic [GW-1:0]     win_id;
  logic [GW:0]       cand;
  logic [1:0]        op_sel;
  logic [IDXW-1:0]   idx_sel;
  logic              sel_oor;
  logic              q_bit;

  // Round-robin search: first pending request at or after ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NREQ)) begin
        cand = cand - (GW+1)'(NREQ);
      end
      if (!win_found && req[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[GW-1:0];
      end
    end
  end

  // Pick the winner's opcode/index and flag indices beyond the bank.
  always_comb begin
    op_sel  = '0;
    idx_sel = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (win_id == GW'(r)) begin
        op_sel  = op[2*r +: 2];
        idx_sel = idx[IDXW*r +: IDXW];
      end
    end
    sel_oor = (int'(idx_sel) >= NFF);
  end

  // Read back the Q of the latched target flop.
  always_comb begin
    q_bit = 1'b0;
    for (int i = 0; i < NFF; i++) begin
      if (int'(idx_q) == i) begin
        q_bit = q_in[i];
      end
    end
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
      ack_q   <= '0;
      rdata_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      j_q     <= j_d;
      k_q     <= k_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and registered-output logic; J/K and ack default to idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    j_d     = '0;
    k_d     = '0;
    ack_d   = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_DRIVE;
          gnt_d   = win_id;
          idx_d   = idx_sel;
          oor_d   = sel_oor;
          busy_d  = 1'b1;
          for (int i = 0; i < NFF; i++) begin
            if (!sel_oor && int'(idx_sel) == i) begin
              j_d[i] = op_sel[1];
              k_d[i] = op_sel[0];
            end
          end
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_DONE;
        for (int r = 0; r < NREQ; r++) begin
          ack_d[r] = (gnt_q == GW'(r));
        end
        rdata_d = q_bit & ~oor_q;
        err_d   = oor_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ptr_d   = (gnt_q == GW'(NREQ-1)) ? '0 : gnt_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign j_out  = j_q;
  assign k_out  = k_q;
  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_bank_arbiter
//  Purpose  : Self-checking bench for jk_bank_arbiter with a behavioural
//             JK flop bank (NFF=6 so that indices 6 and 7 are out of range).
//  Revision : 1.0  initial release
// ============================================================================
module tb_jk_bank_arbiter;

  localparam int NREQ = 4;
  localparam int NFF  = 6;
  localparam int IDXW = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [2*NREQ-1:0]       op;
  logic [IDXW*NREQ-1:0]    idx;
  logic [NFF-1:0]          q_in;
  logic [NFF-1:0]          j_out;
  logic [NFF-1:0]          k_out;
  logic [NREQ-1:0]         ack;
  logic                    rdata;
  logic                    err;
  logic                    busy;
  logic [1:0]              gnt_id;

  logic [NFF-1:0]          bank_q;
  logic                    bank_clr;

  int n_tests = 0;
  int n_fail  = 0;

  jk_bank_arbiter #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .q_in(q_in),
    .j_out(j_out), .k_out(k_out), .ack(ack), .rdata(rdata), .err(err),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  // Behavioural JK flop bank driven by the arbiter.
  always_ff @(posedge clk) begin
    if (bank_clr) begin
      bank_q <= '0;
    end else begin
      for (int i = 0; i < NFF; i++) begin
        case ({j_out[i], k_out[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end
  assign q_in = bank_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int              r;
    logic [1:0]      o;
    logic [IDXW-1:0] ix;
    logic [NFF-1:0]  ej;
    logic [NFF-1:0]  ek;
    logic [NREQ-1:0] eack;
    logic            erd;
    logic            eerr;
  } vec_t;

  vec_t vecs[8];

  logic [NFF-1:0]  res_j, res_k;
  logic [NREQ-1:0] res_ack;
  logic            res_rdata, res_err, res_busy;
  logic [1:0]      res_gnt;
  int              res_jk_cyc, res_lat;

  // One single-requester transaction: drive, observe J/K and ack, then idle.
  task automatic run_txn(input int r, input logic [1:0] o, input logic [IDXW-1:0] ix);
    @(negedge clk);
    req = '0; req[r] = 1'b1;
    op  = '0; op[2*r +: 2] = o;
    idx = '0; idx[IDXW*r +: IDXW] = ix;
    res_j = '0; res_k = '0; res_ack = '0; res_jk_cyc = 0; res_lat = -1;
    res_rdata = 1'b0; res_err = 1'b0; res_busy = 1'b0; res_gnt = '0;
    for (int c = 1; c <= 20 && res_lat < 0; c++) begin
      @(posedge clk); #1;
      res_j = res_j | j_out;
      res_k = res_k | k_out;
      if ((j_out | k_out) != '0) res_jk_cyc++;
      if (ack != '0) begin
        res_lat = c; res_ack = ack; res_rdata = rdata; res_err = err;
        res_busy = busy; res_gnt = gnt_id;
        req = '0;
      end
    end
    chk("ack_latency", res_lat, 3);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 1'b0);
    chk("ack_after_done", ack, '0);
  endtask

  logic [NREQ-1:0] rr_ack[5];
  logic [1:0]      rr_gnt[5];
  logic            rr_rd[5];
  int              rr_t[5];
  int              rr_n;
  logic [NREQ-1:0] ack_or;

  initial begin
    vecs[0] = '{r:0, o:2'b10, ix:3'd5, ej:6'h20, ek:6'h00, eack:4'b0001, erd:1'b1, eerr:1'b0};
    vecs[1] = '{r:0, o:2'b11, ix:3'd5, ej:6'h20, ek:6'h20, eack:4'b0001, erd:1'b0, eerr:1'b0};
    vecs[2] = '{r:2, o:2'b10, ix:3'd3, ej:6'h08, ek:6'h00, eack:4'b0100, erd:1'b1, eerr:1'b0};
    vecs[3] = '{r:2, o:2'b00, ix:3'd3, ej:6'h00, ek:6'h00, eack:4'b0100, erd:1'b1, eerr:1'b0};
    vecs[4] = '{r:1, o:2'b10, ix:3'd7, ej:6'h00, ek:6'h00, eack:4'b0010, erd:1'b0, eerr:1'b1};
    vecs[5] = '{r:3, o:2'b01, ix:3'd3, ej:6'h00, ek:6'h08, eack:4'b1000, erd:1'b0, eerr:1'b0};
    vecs[6] = '{r:1, o:2'b11, ix:3'd0, ej:6'h01, ek:6'h01, eack:4'b0010, erd:1'b1, eerr:1'b0};
    vecs[7] = '{r:3, o:2'b00, ix:3'd6, ej:6'h00, ek:6'h00, eack:4'b1000, erd:1'b0, eerr:1'b1};

    // Reset then idle
    rst = 1'b1; bank_clr = 1'b1; req = '0; op = '0; idx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_jk", {j_out, k_out}, '0);
    chk("rst_ack_busy", {ack, busy, rdata, err}, '0);
    chk("rst_gnt", gnt_id, 2'd0);
    @(negedge clk); rst = 1'b0; bank_clr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_quiet", {j_out, k_out, ack, busy}, '0);
    end

    // Table-driven single-requester operations
    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].r, vecs[v].o, vecs[v].ix);
      chk($sformatf("v%0d_ack", v), res_ack, vecs[v].eack);
      chk($sformatf("v%0d_rdata", v), res_rdata, vecs[v].erd);
      chk($sformatf("v%0d_err", v), res_err, vecs[v].eerr);
      chk($sformatf("v%0d_gnt", v), res_gnt, vecs[v].r);
      chk($sformatf("v%0d_j", v), res_j, vecs[v].ej);
      chk($sformatf("v%0d_k", v), res_k, vecs[v].ek);
      chk($sformatf("v%0d_jk_cycles", v), res_jk_cyc, ((vecs[v].ej | vecs[v].ek) != '0) ? 1 : 0);
      chk($sformatf("v%0d_busy_at_ack", v), res_busy, 1'b1);
    end

    // Round-robin fairness with all four requesting continuously
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req = 4'b1111; op = 8'b10101010; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    rr_n = 0;
    for (int c = 1; c <= 40 && rr_n < 5; c++) begin
      @(posedge clk); #1;
      if (ack != '0) begin
        rr_ack[rr_n] = ack; rr_gnt[rr_n] = gnt_id; rr_rd[rr_n] = rdata; rr_t[rr_n] = c;
        rr_n++;
        if (rr_n == 5) req = '0;
      end
    end
    chk("rr_count", rr_n, 5);
    for (int n = 0; n < rr_n; n++) begin
      chk($sformatf("rr%0d_ack", n), rr_ack[n], 4'b0001 << (n % 4));
      chk($sformatf("rr%0d_gnt", n), rr_gnt[n], n % 4);
      chk($sformatf("rr%0d_rdata", n), rr_rd[n], 1'b1);
      if (n > 0) chk($sformatf("rr%0d_spacing", n), rr_t[n] - rr_t[n-1], 4);
    end
    repeat (2) @(posedge clk);

    // Reset during DRIVE: requester 3 clears flop 2 (currently 1)
    @(negedge clk);
    req = 4'b1000; op = 8'b01_000000; idx = {3'd2, 9'd0};
    @(posedge clk); #1;
    chk("abort_k_driven", k_out, 6'h04);
    rst = 1'b1; req = '0;
    #1;
    chk("abort_jk_zero", {j_out, k_out}, '0);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk); rst = 1'b0;
    ack_or = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      ack_or = ack_or | ack;
    end
    chk("abort_no_ack", ack_or, '0);
    chk("abort_flop_untouched", bank_q[2], 1'b1);

    // ptr back at 0: requesters 0 and 3 together must grant 0 first
    @(negedge clk);
    req = 4'b1001; op = '0; idx = {3'd2, 6'd0, 3'd0};
    res_lat = -1; res_ack = '0; res_gnt = '0;
    for (int c = 1; c <= 20 && res_lat < 0; c++) begin
      @(posedge clk); #1;
      if (ack != '0) begin
        res_lat = c; res_ack = ack; res_gnt = gnt_id; req = '0;
      end
    end
    chk("ptr_reset_ack", res_ack, 4'b0001);
    chk("ptr_reset_gnt", res_gnt, 2'd0);
    repeat (2) @(posedge clk);

    // Requester 3 served normally after the abort
    run_txn(3, 2'b01, 3'd2);
    chk("post_abort_ack", res_ack, 4'b1000);
    chk("post_abort_k", res_k, 6'h04);
    chk("post_abort_j", res_j, 6'h00);
    chk("post_abort_rdata", res_rdata, 1'b0);
    chk("post_abort_err", res_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
